// File: rtl/s2pc_pkg.sv
// Shared types and defaults for the S2PC sequencing controller.
package s2pc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STOP  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int DATA_BITS_DEF = 8;
   localparam int CNT_W_DEF     = 3;

endpackage

// File: rtl/s2pc_if.sv
// Controller <-> serial line / datapath / consumer signals.
// frame_err exists only when S2PC_STOP_CHECK_EN is defined.
interface s2pc_if;
   logic s_in;
   logic out_ack;
   logic shift_en;
   logic done;
   logic busy;
   logic overrun;
`ifdef S2PC_STOP_CHECK_EN
   logic frame_err;
`endif

   modport master (
      input  s_in, out_ack,
`ifdef S2PC_STOP_CHECK_EN
      output frame_err,
`endif
      output shift_en, done, busy, overrun
   );

   modport slave (
      output s_in, out_ack,
`ifdef S2PC_STOP_CHECK_EN
      input  frame_err,
`endif
      input  shift_en, done, busy, overrun
   );
endinterface

// File: rtl/s2pc_edge_det.sv
// Registers the serial line and flags its falling edge (prev high, now low).
module s2pc_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic s_in,
   output logic fall
);
   logic s_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) s_prev <= 1'b1;
      else        s_prev <= s_in;
   end

   assign fall = s_prev & ~s_in;
endmodule

// File: rtl/s2pc_controller.sv
// Sequencing FSM for the S2PC datapath: start detect, DATA_BITS shift clocks, hold until ack.
// Define S2PC_STOP_CHECK_EN to add the STOP state and the sticky frame_err output.
module s2pc_controller
   import s2pc_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic   clk,
   input  logic   rst_n,
   s2pc_if.master bus
);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
   logic             shift_en, done, s_fall, overrun_q;

   s2pc_edge_det u_edge_det (
      .clk   (clk),
      .rst_n (rst_n),
      .s_in  (bus.s_in),
      .fall  (s_fall)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         // a start seen while the word is still unacknowledged is dropped
         overrun_q <= (state == HOLD) && !bus.out_ack && s_fall;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shift_en    = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.s_in) begin
               state_nxt   = SHIFT;
               bit_cnt_nxt = '0;
            end
         end
         SHIFT: begin
            shift_en    = 1'b1;
            bit_cnt_nxt = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
`ifdef S2PC_STOP_CHECK_EN
               state_nxt = STOP;
`else
               state_nxt = HOLD;
`endif
            end
         end
`ifdef S2PC_STOP_CHECK_EN
         STOP: state_nxt = HOLD;
`endif
         HOLD: begin
            done = 1'b1;
            if (bus.out_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef S2PC_STOP_CHECK_EN
   logic frame_err_q;

   // sticky until the next frame starts
   always_ff @(posedge clk) begin
      if (!rst_n)                              frame_err_q <= 1'b0;
      else if (state == IDLE && !bus.s_in)     frame_err_q <= 1'b0;
      else if (state == STOP && !bus.s_in)     frame_err_q <= 1'b1;
   end

   assign bus.frame_err = frame_err_q;
`endif

   assign bus.shift_en = shift_en;
   assign bus.done     = done;
   assign bus.busy     = (state != IDLE);
   assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_s2pc_controller.sv
// Scoreboard bench for s2pc_controller with a behavioural datapath (LSB-first shift, even parity).
module tb_s2pc_controller;
   logic clk = 1'b0;
   logic rst_n;
   s2pc_if bus ();

   s2pc_controller #(.DATA_BITS(8), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   logic [8:0] sb_q[$];
   logic [7:0] sr = '0;
   logic [8:0] parout;
   logic       done_q = 1'b0;
   int         shift_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // datapath stand-in
   always @(posedge clk) if (bus.shift_en) sr <= {bus.s_in, sr[7:1]};
   assign parout = {^sr, sr};

   always @(negedge clk) begin
      if (!rst_n) begin
         shift_cnt = 0;
         done_q    = 1'b0;
      end else begin
         if (bus.shift_en) shift_cnt++;
         if (bus.done && !done_q) begin
            chk("excl", 32'(bus.shift_en & bus.done), 0);
            chk("busy_hold", 32'(bus.busy), 1);
            chk("shift_cnt", shift_cnt, 8);
            chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) chk("parout", 32'(parout), 32'(sb_q.pop_front()));
            shift_cnt = 0;
         end
         done_q = bus.done;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit push);
      if (push) sb_q.push_back({^d, d});
      bus.s_in = 1'b0; tick();
      for (int k = 0; k < 8; k++) begin
         bus.s_in = d[k]; tick();
      end
`ifdef S2PC_STOP_CHECK_EN
      bus.s_in = stop_bit; tick();
`endif
      bus.s_in = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; bus.s_in = 1'b0; bus.out_ack = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_shift_en", 32'(bus.shift_en), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_overrun", 32'(bus.overrun), 0);
`ifdef S2PC_STOP_CHECK_EN
      chk("rst_frame_err", 32'(bus.frame_err), 0);
`endif
      rst_n = 1'b1; bus.s_in = 1'b1;
      tick(); tick();
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 0);

      // 0xA5 with immediate ack: done exactly one cycle
      bus.out_ack = 1'b1;
      send_frame(8'hA5, 1'b1, 1);
      @(negedge clk);
      chk("a5_done", 32'(bus.done), 1);
      tick();
      @(negedge clk);
      chk("a5_done_drop", 32'(bus.done), 0);
      chk("a5_busy", 32'(bus.busy), 0);

      // 0x07 held unacked for 5 cycles
      bus.out_ack = 1'b0;
      send_frame(8'h07, 1'b1, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("07_done_hold", 32'(bus.done), 1);
         chk("07_parout_hold", 32'(parout), 32'h107);
         tick();
      end
      bus.out_ack = 1'b1; tick();
      @(negedge clk);
      chk("07_done_after_ack", 32'(bus.done), 0);
      bus.out_ack = 1'b0;

      // start bit arrives while word unacknowledged
      send_frame(8'h5A, 1'b1, 1);
      tick();
      bus.s_in = 1'b0;
      @(negedge clk);
      chk("ovr_pre", 32'(bus.overrun), 0);
      tick(); bus.s_in = 1'b1;
      @(negedge clk);
      chk("ovr_pulse", 32'(bus.overrun), 1);
      chk("ovr_done", 32'(bus.done), 1);
      chk("ovr_word", 32'(parout), 32'h05A);
      tick();
      @(negedge clk);
      chk("ovr_clear", 32'(bus.overrun), 0);
      bus.out_ack = 1'b1; tick();
      @(negedge clk);
      chk("ovr_ack_idle", 32'(bus.busy), 0);

      // back-to-back frames at minimum spacing
      send_frame(8'h12, 1'b1, 1);
      tick();
      send_frame(8'hE7, 1'b1, 1);
      tick(); tick();
      bus.out_ack = 1'b0;

`ifdef S2PC_STOP_CHECK_EN
      send_frame(8'h3C, 1'b0, 1);
      @(negedge clk);
      chk("ferr_set", 32'(bus.frame_err), 1);
      chk("ferr_done", 32'(bus.done), 1);
      bus.out_ack = 1'b1; tick();
      @(negedge clk);
      chk("ferr_sticky", 32'(bus.frame_err), 1);
      bus.out_ack = 1'b0;
      send_frame(8'h81, 1'b1, 1);
      @(negedge clk);
      chk("ferr_clear", 32'(bus.frame_err), 0);
      bus.out_ack = 1'b1; tick();
      bus.out_ack = 1'b0;
`endif

      // reset during data bit 4, then a clean 0xFF
      bus.s_in = 1'b0; tick();
      for (int k = 0; k < 4; k++) begin
         bus.s_in = k[0]; tick();
      end
      bus.s_in = 1'b0; rst_n = 1'b0; tick();
      @(negedge clk);
      chk("mid_rst_busy", 32'(bus.busy), 0);
      chk("mid_rst_shift", 32'(bus.shift_en), 0);
      rst_n = 1'b1; bus.s_in = 1'b1; tick(); tick();
      bus.out_ack = 1'b1;
      send_frame(8'hFF, 1'b1, 1);
      @(negedge clk);
      chk("ff_done", 32'(bus.done), 1);
      tick(); tick();

      chk("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
